// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester arbitrated mux.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer cell: y = s ? a1 : a0.
module mux2x1 (
  input  logic a0,
  input  logic a1,
  input  logic s,
  output logic y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin, hold-limited arbiter sharing one registered 2:1 mux between two requesters.
module mux2x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] y,
  output logic         y_valid
);

  localparam int CNT_W = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             last;
  logic [W-1:0]     mux_y;
  logic             owner_active;

  for (genvar i = 0; i < W; i++) begin : g_mux
    mux2x1 u_mux (
      .a0 (d0[i]),
      .a1 (d1[i]),
      .s  (sel),
      .y  (mux_y[i])
    );
  end

  assign gnt0         = (state == ST_OWN0);
  assign gnt1         = (state == ST_OWN1);
  assign owner_active = (gnt0 & req0) | (gnt1 & req1);

  // hold_cnt only advances while the other side is waiting, so an uncontested
  // owner keeps the path indefinitely; sel is left alone on entry to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      sel      <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      y_valid <= owner_active;
      if (owner_active) begin
        y <= mux_y;
      end

      case (state)
        ST_IDLE: begin
          if (req0 && (!req1 || last)) begin
            state    <= ST_OWN0;
            sel      <= 1'b0;
            hold_cnt <= '0;
          end else if (req1) begin
            state    <= ST_OWN1;
            sel      <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_OWN0: begin
          if (!req0 || (req1 && hold_cnt == HOLD_LAST)) begin
            last     <= 1'b0;
            hold_cnt <= '0;
            if (req1) begin
              state <= ST_OWN1;
              sel   <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (req1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_OWN1: begin
          if (!req1 || (req0 && hold_cnt == HOLD_LAST)) begin
            last     <= 1'b1;
            hold_cnt <= '0;
            if (req0) begin
              state <= ST_OWN0;
              sel   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (req0) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Bench for mux2x1_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model for MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux2x1_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [7:0] d0;
  logic [7:0] d1;

  logic       g0  [2];
  logic       g1  [2];
  logic       sl  [2];
  logic [7:0] yy  [2];
  logic       yv  [2];

  int tests_run;
  int tests_failed;

  mux2x1_arbiter #(.W(8), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(g0[0]), .gnt1(g1[0]), .sel(sl[0]), .y(yy[0]), .y_valid(yv[0])
  );

  mux2x1_arbiter #(.W(8), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(g0[1]), .gnt1(g1[1]), .sel(sl[1]), .y(yy[1]), .y_valid(yv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner is -1 when idle, otherwise the index holding the path;
  // streak counts consecutive cycles the owner kept the path while the other waited.
  int         hold_lim [2] = '{4, 1};
  int         m_owner  [2];
  int         m_streak [2];
  int         m_last   [2];
  logic       m_sel    [2];
  logic [7:0] m_y      [2];
  logic       m_yv     [2];
  bit         m_ok = 1'b0;

  always @(posedge clk) begin
    logic       r  [2];
    logic [7:0] dd [2];
    int         o;
    int         p;
    r[0]  = req0;
    r[1]  = req1;
    dd[0] = d0;
    dd[1] = d1;
    if (rst) m_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k]  = -1;
        m_streak[k] = 0;
        m_last[k]   = 1;
        m_sel[k]    = 1'b0;
        m_y[k]      = 8'h00;
        m_yv[k]     = 1'b0;
      end else begin
        o = m_owner[k];
        m_yv[k] = (o >= 0) && r[o];
        if (m_yv[k]) m_y[k] = dd[o];
        if (o < 0) begin
          if (r[0] && r[1]) m_owner[k] = 1 - m_last[k];
          else if (r[0])    m_owner[k] = 0;
          else if (r[1])    m_owner[k] = 1;
          if (m_owner[k] >= 0) begin
            m_streak[k] = 0;
            m_sel[k]    = (m_owner[k] == 1);
          end
        end else begin
          p = 1 - o;
          if (!r[o] || (r[p] && m_streak[k] + 1 >= hold_lim[k])) begin
            m_last[k]   = o;
            m_streak[k] = 0;
            if (r[p]) begin
              m_owner[k] = p;
              m_sel[k]   = (p == 1);
            end else begin
              m_owner[k] = -1;
            end
          end else if (r[p]) begin
            m_streak[k] = m_streak[k] + 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, once the model has seen a reset, both DUTs must agree with it
  always @(negedge clk) begin
    if (m_ok) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model gnt0 dut%0d", k), {7'd0, g0[k]}, {7'd0, m_owner[k] == 0});
        checkOutput($sformatf("model gnt1 dut%0d", k), {7'd0, g1[k]}, {7'd0, m_owner[k] == 1});
        checkOutput($sformatf("model sel dut%0d", k), {7'd0, sl[k]}, {7'd0, m_sel[k]});
        checkOutput($sformatf("model y_valid dut%0d", k), {7'd0, yv[k]}, {7'd0, m_yv[k]});
        checkOutput($sformatf("model y dut%0d", k), yy[k], m_y[k]);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic q0, input logic q1,
                               input logic [7:0] a, input logic [7:0] b);
    rst  = r;
    req0 = q0;
    req1 = q1;
    d0   = a;
    d1   = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    applyStimulus(1, 1, 1, 8'hA5, 8'h3C);
    applyStimulus(1, 1, 1, 8'hA5, 8'h3C);
    checkOutput("reset gnt0", {7'd0, g0[0]}, 8'd0);
    checkOutput("reset gnt1", {7'd0, g1[0]}, 8'd0);
    checkOutput("reset sel", {7'd0, sl[0]}, 8'd0);
    checkOutput("reset y_valid", {7'd0, yv[0]}, 8'd0);
    checkOutput("reset y", yy[0], 8'h00);

    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("first tie gnt0", {7'd0, g0[0]}, 8'd1);
    checkOutput("first tie gnt1", {7'd0, g1[0]}, 8'd0);

    applyStimulus(0, 1, 0, 8'hA5, 8'h3C);
    checkOutput("single y_valid", {7'd0, yv[0]}, 8'd1);
    checkOutput("single y", yy[0], 8'hA5);
    repeat (4) applyStimulus(0, 1, 0, 8'hA5, 8'h3C);
    checkOutput("single gnt0 held", {7'd0, g0[0]}, 8'd1);

    repeat (3) applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("hold gnt0 third", {7'd0, g0[0]}, 8'd1);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("hold switch gnt1", {7'd0, g1[0]}, 8'd1);
    checkOutput("hold switch gnt0", {7'd0, g0[0]}, 8'd0);
    checkOutput("hold switch sel", {7'd0, sl[0]}, 8'd1);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("hold y d1", yy[0], 8'h3C);
    repeat (2) applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("hold gnt1 fourth", {7'd0, g1[0]}, 8'd1);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("hold back gnt0", {7'd0, g0[0]}, 8'd1);
    checkOutput("hold back sel", {7'd0, sl[0]}, 8'd0);
    repeat (4) applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("repeat gnt1", {7'd0, g1[0]}, 8'd1);

    applyStimulus(0, 1, 0, 8'hA5, 8'h3C);
    checkOutput("handoff gnt0", {7'd0, g0[0]}, 8'd1);
    checkOutput("handoff gnt1", {7'd0, g1[0]}, 8'd0);
    checkOutput("handoff y_valid gap", {7'd0, yv[0]}, 8'd0);
    applyStimulus(0, 1, 0, 8'hA5, 8'h3C);
    checkOutput("handoff y_valid back", {7'd0, yv[0]}, 8'd1);
    checkOutput("handoff y", yy[0], 8'hA5);

    applyStimulus(0, 0, 0, 8'h11, 8'h22);
    checkOutput("idle gnt0", {7'd0, g0[0]}, 8'd0);
    checkOutput("idle y_valid", {7'd0, yv[0]}, 8'd0);
    checkOutput("idle y holds", yy[0], 8'hA5);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("rr tie gnt1", {7'd0, g1[0]}, 8'd1);
    checkOutput("rr tie gnt0", {7'd0, g0[0]}, 8'd0);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("rr y_valid", {7'd0, yv[0]}, 8'd1);
    checkOutput("rr y", yy[0], 8'h3C);

    applyStimulus(1, 1, 1, 8'hA5, 8'h3C);
    checkOutput("midreset gnt1", {7'd0, g1[0]}, 8'd0);
    checkOutput("midreset sel", {7'd0, sl[0]}, 8'd0);
    checkOutput("midreset y_valid", {7'd0, yv[0]}, 8'd0);
    checkOutput("midreset y", yy[0], 8'h00);
    applyStimulus(0, 1, 1, 8'hA5, 8'h3C);
    checkOutput("after reset gnt0", {7'd0, g0[0]}, 8'd1);

    // Sticky random requests so grants last long enough to hit the hold limit
    begin
      logic r0;
      logic r1;
      r0 = 1'b0;
      r1 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(3) == 0) r0 = ~r0;
        if ($urandom_range(3) == 0) r1 = ~r1;
        applyStimulus(($urandom_range(59) == 0), r0, r1,
                      8'($urandom_range(255)), 8'($urandom_range(255)));
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux2x1_arbiter.md
Name: mux2x1_arbiter

Overview:
Shares one 2:1 multiplexed datapath between two requesters. Runs a round-robin, hold-limited grant state machine. Drives the mux select and a registered output stage with a valid flag. Sits in front of any consumer that takes one data stream from two producers.

Parameters:
W, 8, data width of d0/d1/y
MAX_HOLD, 4, max consecutive grant cycles for one owner while the other requests (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 wants the path; held high for the whole transfer
req1  input  1  requester 1 wants the path
d0  input  W  requester 0 data
d1  input  W  requester 1 data
gnt0  output  1  registered grant to requester 0
gnt1  output  1  registered grant to requester 1
sel  output  1  mux select: 0 = d0, 1 = d1; equals owner of current grant
y  output  W  registered muxed data
y_valid  output  1  y holds data from a granted requester

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk. All outputs are 0 at the next edge: gnt0, gnt1, sel, y, y_valid. State = IDLE, hold counter = 0, last = 1, so requester 0 wins the first tie. Reset mid-grant aborts the transfer with no drain.
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1). Never both high. sel = 1 only in OWN1; sel holds its last value in IDLE.
- IDLE:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - Both -> the requester != last.
  - Neither -> stay.
  - Grant appears one cycle after req is first sampled high.
- OWNx, per edge:
  - Owner req low, other req high -> switch directly to the other owner (no IDLE bubble).
  - Owner req low, other req low -> IDLE.
  - Owner req high, other req high, hold counter == MAX_HOLD-1 -> forced switch to the other owner.
  - Otherwise stay and increment the hold counter, saturating at MAX_HOLD-1.
- Hold counter: clears on every state change. Counts only while the other requester is high; it is held (not cleared) while the other is low. Width = clog2(MAX_HOLD) bits, minimum 1.
- last: updates to the owner index on every exit from OWNx.
- Datapath, one cycle latency from grant:
  - y <= (sel ? d1 : d0) whenever gnt0|gnt1 and the owner's req is high; otherwise y holds.
  - y_valid <= (gnt0 & req0) | (gnt1 & req1).
  - So y_valid drops in the same cycle the owner deasserts req.
- MAX_HOLD=1: alternates every cycle under continuous dual request.
- A req pulse shorter than one cycle between edges is not seen. Requesters must hold req until granted.

Decomposition:
- Shared package mux_arb_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Helper constant function clog2.
- Datapath: instantiate the existing mux2x1 cell once per bit via a generate loop (a0=d0[i], a1=d1[i], s=sel). Register its output inside mux2x1_arbiter.
- FSM, counter and output register stay in the top. No further sub-modules.

Test Plan:
- Reset: assert rst 2 cycles with req0=req1=1 -> gnt0=gnt1=sel=y_valid=0, y=0. Release -> gnt0=1 one cycle later (last=1 tie-break).
- Single requester: req0=1, d0=8'hA5 for 6 cycles, req1=0 -> gnt0 high continuously, y=8'hA5 and y_valid=1 from cycle 2. Drop req0 -> next edge IDLE, y_valid=0, y holds 8'hA5.
- Hold limit: MAX_HOLD=4, req0 granted, then req1 rises and both stay high -> gnt0 lasts exactly 4 cycles after req1 is seen, then gnt1, sel=1, y=d1 (8'h3C) one cycle later. Pattern repeats 4/4.
- Direct handoff: owner 1 drops req1 while req0=1 -> next edge gnt1=0, gnt0=1, no IDLE cycle, y_valid low for exactly one cycle.
- Round-robin tie from IDLE: last grant was OWN0, both req rise together -> gnt1 first.
- Reset mid-grant: rst during OWN1 with y_valid=1 -> next edge all outputs 0. After release with req0=req1=1 -> gnt0 (last reset to 1).
